fx_mailbox_sequencer: RTL and testbench

//  Sole owner of the local mailbox RAM port; runs the per-sample exchange with the host processor.
//  Per sample: announces readiness, polls for host completion, fetches sample and effect settings,

---
 rtl/fx_mailbox_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_fx_mailbox_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_mailbox_sequencer.sv
// fx_mailbox_sequencer: owns the local mailbox RAM port and runs the per-sample
// exchange with the host (announce ready, poll, fetch, process, write back).
// Ports:
//   clk, reset (async, active-low), enable, err_clr
//   loc_*     : mailbox RAM port; loc_ramclk is generated here, 3 clk per access
//   fx_*      : request/result handshake with the effect datapath
//   busy, timeout_err (sticky), sample_count (wrapping)
module fx_mailbox_sequencer #(
    parameter logic [31:0] READY_MAGIC  = 32'd1100,
    parameter logic [15:0] POLL_TIMEOUT = 16'd50000,
    parameter logic [15:0] FX_TIMEOUT   = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        err_clr,
    input  logic [31:0] loc_readdata,
    output logic [31:0] loc_writedata,
    output logic [4:0]  loc_ramaddress,
    output logic        loc_ramclk,
    output logic        loc_ramread,
    output logic        loc_ramwrite,
    output logic [31:0] fx_sample,
    output logic [31:0] fx_select,
    output logic [31:0] fx_gain,
    output logic [31:0] fx_boost,
    output logic        fx_valid,
    input  logic        fx_ready,
    input  logic [31:0] fx_result,
    input  logic        fx_result_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] sample_count
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    localparam logic [AW-1:0] ADD_SE           = AW'(0);
    localparam logic [AW-1:0] ADD_GAIN         = AW'(1);
    localparam logic [AW-1:0] ADD_BOOST        = AW'(2);
    localparam logic [AW-1:0] ADD_INPUT        = AW'(3);
    localparam logic [AW-1:0] ADD_READ_FINISH  = AW'(4);
    localparam logic [AW-1:0] ADD_OUTPUT       = AW'(5);
    localparam logic [AW-1:0] ADD_READY_TO_GET = AW'(6);

    typedef enum logic [3:0] {
        IDLE, RDY_WR, POLL, RD_SE, RD_GAIN, RD_BOOST, RD_IN,
        CLR_FIN, FX_REQ, FX_WAIT, OUT_WR
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t          state, state_d;
    phase_t          phase;
    logic            launch, acc_done, poll_zero, poll_expire, fx_expire, set_err;
    logic [CW-1:0]   poll_cnt, fx_tmr;
    logic [DW-1:0]   out_data_d;

    function automatic logic is_ram(input state_t s);
        return !(s == IDLE || s == FX_REQ || s == FX_WAIT);
    endfunction

    function automatic logic is_fx(input state_t s);
        return (s == FX_REQ || s == FX_WAIT);
    endfunction

    function automatic logic is_write(input state_t s);
        return (s == RDY_WR || s == CLR_FIN || s == OUT_WR);
    endfunction

    function automatic logic [AW-1:0] addr_of(input state_t s);
        case (s)
            RDY_WR:        return ADD_READY_TO_GET;
            POLL, CLR_FIN: return ADD_READ_FINISH;
            RD_SE:         return ADD_SE;
            RD_GAIN:       return ADD_GAIN;
            RD_BOOST:      return ADD_BOOST;
            RD_IN:         return ADD_INPUT;
            OUT_WR:        return ADD_OUTPUT;
            default:       return ADD_SE;
        endcase
    endfunction

    // Next state; RAM states advance only once their hold phase ends.
    always_comb begin
        state_d     = state;
        set_err     = 1'b0;
        out_data_d  = '0;
        acc_done    = is_ram(state) && (phase == PH_HOLD);
        poll_zero   = (loc_readdata == '0);
        poll_expire = (poll_cnt == POLL_TIMEOUT - 16'd1);
        fx_expire   = (fx_tmr >= FX_TIMEOUT - 16'd1);
        case (state)
            IDLE:     if (enable) state_d = RDY_WR;
            RDY_WR:   if (acc_done) state_d = POLL;
            POLL: begin
                if (acc_done) begin
                    if (!poll_zero) begin
                        state_d = RD_SE;
                    end else if (poll_expire) begin
                        state_d = RDY_WR;
                        set_err = 1'b1;
                    end else if (!enable) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_SE:    if (acc_done) state_d = RD_GAIN;
            RD_GAIN:  if (acc_done) state_d = RD_BOOST;
            RD_BOOST: if (acc_done) state_d = RD_IN;
            RD_IN:    if (acc_done) state_d = CLR_FIN;
            CLR_FIN:  if (acc_done) state_d = FX_REQ;
            FX_REQ: begin
                if (fx_ready) begin
                    state_d = FX_WAIT;
                end else if (fx_expire) begin
                    state_d = OUT_WR;
                    set_err = 1'b1;
                end
            end
            FX_WAIT: begin
                // A result arriving on the last allowed cycle still counts.
                if (fx_result_valid) begin
                    state_d    = OUT_WR;
                    out_data_d = fx_result;
                end else if (fx_expire) begin
                    state_d = OUT_WR;
                    set_err = 1'b1;
                end
            end
            OUT_WR:   if (acc_done) state_d = enable ? RDY_WR : IDLE;
            default:  state_d = IDLE;
        endcase
        // Start a fresh access whenever we land in a RAM state (incl. POLL repeating).
        launch = is_ram(state_d) && (acc_done || !is_ram(state));
    end

    // State, RAM phase sequencing and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            phase          <= PH_SETUP;
            loc_writedata  <= '0;
            loc_ramaddress <= '0;
            loc_ramclk     <= 1'b0;
            loc_ramread    <= 1'b0;
            loc_ramwrite   <= 1'b0;
            fx_sample      <= '0;
            fx_select      <= '0;
            fx_gain        <= '0;
            fx_boost       <= '0;
            fx_valid       <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            sample_count   <= '0;
            poll_cnt       <= '0;
            fx_tmr         <= '0;
        end else begin
            state    <= state_d;
            busy     <= (state_d != IDLE);
            fx_valid <= (state_d == FX_REQ);
            fx_tmr   <= (is_fx(state) && is_fx(state_d)) ? fx_tmr + 16'd1 : '0;

            if (set_err) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            if (launch) begin
                phase          <= PH_SETUP;
                loc_ramclk     <= 1'b0;
                loc_ramaddress <= addr_of(state_d);
                loc_ramwrite   <= is_write(state_d);
                loc_ramread    <= !is_write(state_d);
                loc_writedata  <= (state_d == RDY_WR) ? READY_MAGIC :
                                  (state_d == OUT_WR) ? out_data_d : '0;
            end else if (is_ram(state)) begin
                case (phase)
                    PH_SETUP: begin
                        loc_ramclk <= 1'b1;
                        phase      <= PH_STROBE;
                    end
                    PH_STROBE: begin
                        loc_ramclk   <= 1'b0;
                        loc_ramread  <= 1'b0;
                        loc_ramwrite <= 1'b0;
                        phase        <= PH_HOLD;
                    end
                    default: phase <= PH_SETUP;
                endcase
            end

            if (acc_done) begin
                case (state)
                    RD_SE:    fx_select    <= loc_readdata;
                    RD_GAIN:  fx_gain      <= loc_readdata;
                    RD_BOOST: fx_boost     <= loc_readdata;
                    RD_IN:    fx_sample    <= loc_readdata;
                    OUT_WR:   sample_count <= sample_count + 16'd1;
                    POLL:     poll_cnt     <= (poll_zero && !poll_expire && enable) ?
                                              poll_cnt + 16'd1 : '0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fx_mailbox_sequencer.sv
// Bench for fx_mailbox_sequencer: behavioural mailbox RAM, datapath responder,
// RAM port protocol monitor and directed/random sample transactions.
module tb_fx_mailbox_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        err_clr;
    logic [31:0] ram_rdata = '0;
    logic [31:0] loc_writedata;
    logic [4:0]  loc_ramaddress;
    logic        loc_ramclk, loc_ramread, loc_ramwrite;
    logic [31:0] fx_sample, fx_select, fx_gain, fx_boost;
    logic        fx_valid;
    logic        fx_ready;
    logic [31:0] fx_result;
    logic        fx_result_valid;
    logic        busy, timeout_err;
    logic [15:0] sample_count;

    fx_mailbox_sequencer #(
        .READY_MAGIC (32'd1100),
        .POLL_TIMEOUT(16'd4),
        .FX_TIMEOUT  (16'd16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .err_clr        (err_clr),
        .loc_readdata   (ram_rdata),
        .loc_writedata  (loc_writedata),
        .loc_ramaddress (loc_ramaddress),
        .loc_ramclk     (loc_ramclk),
        .loc_ramread    (loc_ramread),
        .loc_ramwrite   (loc_ramwrite),
        .fx_sample      (fx_sample),
        .fx_select      (fx_select),
        .fx_gain        (fx_gain),
        .fx_boost       (fx_boost),
        .fx_valid       (fx_valid),
        .fx_ready       (fx_ready),
        .fx_result      (fx_result),
        .fx_result_valid(fx_result_valid),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .sample_count   (sample_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- mailbox RAM with access log ----------------
    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        int          stamp;
    } acc_t;
    acc_t        log_q[$];
    logic [31:0] mem [0:31];
    logic        host_we = 1'b0;
    logic [4:0]  host_addr = '0;
    logic [31:0] host_data = '0;

    always @(posedge loc_ramclk or posedge host_we) begin
        if (host_we) begin
            mem[host_addr] = host_data;
        end else begin
            if (loc_ramwrite) mem[loc_ramaddress] = loc_writedata;
            if (loc_ramread)  ram_rdata = mem[loc_ramaddress];
            log_q.push_back('{loc_ramwrite, loc_ramaddress,
                              loc_ramwrite ? loc_writedata : mem[loc_ramaddress], cyc});
        end
    end

    // ---------------- RAM port protocol monitor ----------------
    int   proto_err = 0;
    logic p_ok = 1'b0, p_clk = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_wd = '0;
    always @(negedge clk) begin
        if (!reset) begin
            p_ok = 1'b0;
        end else begin
            if (loc_ramread && loc_ramwrite) proto_err++;
            if (p_ok) begin
                // strobe phase must follow a matching setup phase
                if (loc_ramclk && !((p_rd || p_wr) && !p_clk && p_rd == loc_ramread &&
                    p_wr == loc_ramwrite && p_addr == loc_ramaddress && p_wd == loc_writedata))
                    proto_err++;
                // hold phase: clock low, strobes low, address unchanged
                if (p_clk && (loc_ramclk || loc_ramread || loc_ramwrite || loc_ramaddress != p_addr))
                    proto_err++;
                // setup phase must be followed by the strobe phase
                if ((p_rd || p_wr) && !p_clk && !loc_ramclk) proto_err++;
                // a new setup may not directly follow a strobe phase
                if ((loc_ramread || loc_ramwrite) && !loc_ramclk && p_clk) proto_err++;
            end
            p_ok = 1'b1; p_clk = loc_ramclk; p_rd = loc_ramread; p_wr = loc_ramwrite;
            p_addr = loc_ramaddress; p_wd = loc_writedata;
        end
    end

    // ---------------- effect datapath responder ----------------
    int          dp_ready_lat = 0, dp_res_lat = 0;
    logic        dp_respond = 1'b1;
    int          dp_hold_err = 0, dp_strobe_err = 0;
    logic [31:0] cap_sample = '0, cap_select = '0, cap_gain = '0, cap_boost = '0;

    initial begin
        fx_ready = 1'b0; fx_result_valid = 1'b0; fx_result = '0;
        forever begin
            @(negedge clk);
            if (fx_valid && reset) begin
                cap_sample = fx_sample; cap_select = fx_select;
                cap_gain = fx_gain; cap_boost = fx_boost;
                for (int i = 0; i < dp_ready_lat; i++) begin
                    @(negedge clk);
                    if (!fx_valid || fx_sample != cap_sample || fx_select != cap_select ||
                        fx_gain != cap_gain || fx_boost != cap_boost) dp_hold_err++;
                    if (loc_ramclk || loc_ramread || loc_ramwrite) dp_strobe_err++;
                end
                fx_ready = 1'b1;
                @(negedge clk);
                fx_ready = 1'b0;
                if (fx_valid) dp_hold_err++;
                if (loc_ramclk || loc_ramread || loc_ramwrite) dp_strobe_err++;
                if (dp_respond) begin
                    for (int i = 0; i < dp_res_lat; i++) begin
                        @(negedge clk);
                        if (loc_ramclk || loc_ramread || loc_ramwrite) dp_strobe_err++;
                    end
                    fx_result = cap_sample + 32'd1;
                    fx_result_valid = 1'b1;
                    @(negedge clk);
                    fx_result_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int          n_checks = 0, n_pass = 0;
    logic [15:0] exp_count = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] acc_word(input logic wr, input logic [4:0] a, input logic [31:0] d);
        return {26'd0, wr, a, wr ? d : 32'd0};
    endfunction

    function automatic logic [63:0] acc_at(input int idx);
        if (idx >= log_q.size()) return '1;
        return acc_word(log_q[idx].wr, log_q[idx].addr, log_q[idx].data);
    endfunction

    function automatic int stamp_at(input int idx);
        if (idx >= log_q.size()) return -1000;
        return log_q[idx].stamp;
    endfunction

    // Expected access sequence of one complete sample.
    function automatic logic [63:0] exp_acc(input int i, input logic [31:0] res);
        case (i)
            0:       return acc_word(1'b1, 5'd6, 32'd1100);
            1:       return acc_word(1'b0, 5'd4, 32'd0);
            2:       return acc_word(1'b0, 5'd0, 32'd0);
            3:       return acc_word(1'b0, 5'd1, 32'd0);
            4:       return acc_word(1'b0, 5'd2, 32'd0);
            5:       return acc_word(1'b0, 5'd3, 32'd0);
            6:       return acc_word(1'b1, 5'd4, 32'd0);
            default: return acc_word(1'b1, 5'd5, res);
        endcase
    endfunction

    task automatic host_write(input logic [4:0] a, input logic [31:0] d);
        host_addr = a; host_data = d;
        #1 host_we = 1'b1;
        #1 host_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic load(input logic [31:0] se, g, b, smp, fin);
        host_write(5'd0, se); host_write(5'd1, g); host_write(5'd2, b);
        host_write(5'd3, smp); host_write(5'd4, fin);
    endtask

    // One sample with enable pulsed; compares the whole transaction to the model.
    task automatic run_sample(input logic [31:0] se, g, b, smp, fin,
                              input int l, r, input string tag);
        int base, h0, s0, p0;
        logic [31:0] res;
        load(se, g, b, smp, fin);
        dp_ready_lat = l; dp_res_lat = r; dp_respond = 1'b1;
        base = log_q.size(); h0 = dp_hold_err; s0 = dp_strobe_err; p0 = proto_err;
        res = smp + 32'd1;
        @(negedge clk); enable = 1'b1;
        @(negedge clk);
        check({tag, " busy"}, 64'(busy), 64'd1);
        enable = 1'b0;
        wait_idle(tag, 300);
        exp_count = exp_count + 16'd1;
        check({tag, " n_acc"}, 64'(log_q.size() - base), 64'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s acc%0d", tag, i), acc_at(base + i), exp_acc(i, res));
        for (int i = 1; i < 7; i++)
            check($sformatf("%s spacing%0d", tag, i),
                  64'(stamp_at(base + i) - stamp_at(base + i - 1)), 64'd3);
        check({tag, " fx_latency"}, 64'(stamp_at(base + 7) - stamp_at(base + 6)), 64'(l + r + 5));
        check({tag, " fx_regs"}, 64'({fx_select ^ fx_gain, fx_boost ^ fx_sample}),
              64'({se ^ g, b ^ smp}));
        check({tag, " fx_sel"}, 64'(fx_select), 64'(se));
        check({tag, " dp_req"}, 64'({cap_sample, cap_gain}), 64'({smp, g}));
        check({tag, " dp_req2"}, 64'({cap_select, cap_boost}), 64'({se, b}));
        check({tag, " out_mem"}, 64'(mem[5]), 64'(res));
        check({tag, " fin_clr"}, 64'(mem[4]), 64'd0);
        check({tag, " count"}, 64'(sample_count), 64'(exp_count));
        check({tag, " no_err"}, 64'(timeout_err), 64'd0);
        check({tag, " hold"}, 64'(dp_hold_err - h0), 64'd0);
        check({tag, " fx_quiet"}, 64'(dp_strobe_err - s0), 64'd0);
        check({tag, " proto"}, 64'(proto_err - p0), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          base, n;
        logic [63:0] pexp [7];
        logic [31:0] smp;

        reset = 1'b0; enable = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst ramclk", 64'(loc_ramclk), 64'd0);
        check("rst strobes", 64'({loc_ramread, loc_ramwrite}), 64'd0);
        check("rst addr_data", 64'({loc_ramaddress, loc_writedata}), 64'd0);
        check("rst fx_valid", 64'(fx_valid), 64'd0);
        check("rst busy_err", 64'({busy, timeout_err}), 64'd0);
        check("rst count", 64'(sample_count), 64'd0);
        check("rst fx_regs", 64'({fx_sample | fx_select, fx_gain | fx_boost}), 64'd0);
        reset = 1'b1;
        base = log_q.size();
        repeat (3) @(negedge clk);
        check("idle stays", 64'({busy, 31'(log_q.size() - base)}), 64'd0);

        run_sample(32'd2, 32'd7, 32'd3, 32'h1234, 32'd1, 2, 4, "basic");
        check("basic result", 64'(mem[5]), 64'h1235);

        run_sample($urandom, $urandom, $urandom, $urandom, 32'd9, 10, 2, "ready_hold");

        // Host never finishes: timeout after 4 zero reads, then re-announce.
        host_write(5'd4, 32'd0);
        base = log_q.size();
        @(negedge clk); enable = 1'b1;
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("poll_to set", 64'(timeout_err), 64'd1);
        enable = 1'b0;
        wait_idle("poll_to", 100);
        pexp[0] = acc_word(1'b1, 5'd6, 32'd1100);
        for (int i = 1; i < 5; i++) pexp[i] = acc_word(1'b0, 5'd4, 32'd0);
        pexp[5] = acc_word(1'b1, 5'd6, 32'd1100);
        pexp[6] = acc_word(1'b0, 5'd4, 32'd0);
        check("poll_to n_acc", 64'(log_q.size() - base), 64'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("poll_to acc%0d", i), acc_at(base + i), pexp[i]);
        check("poll_to count", 64'(sample_count), 64'(exp_count));
        check("poll_to sticky", 64'(timeout_err), 64'd1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_clr", 64'(timeout_err), 64'd0);

        // Datapath accepts but never answers: OUT_WR writes 0, sequencer carries on.
        smp = $urandom;
        load($urandom, $urandom, $urandom, smp, 32'd1);
        dp_respond = 1'b0; dp_ready_lat = 1;
        base = log_q.size();
        @(negedge clk); enable = 1'b1;
        n = 0;
        while (log_q.size() - base < 9 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("fx_to reach", 64'(log_q.size() - base >= 9), 64'd1);
        enable = 1'b0;
        wait_idle("fx_to", 100);
        exp_count = exp_count + 16'd1;
        check("fx_to n_acc", 64'(log_q.size() - base), 64'd10);
        check("fx_to out0", acc_at(base + 7), acc_word(1'b1, 5'd5, 32'd0));
        check("fx_to rdy", acc_at(base + 8), acc_word(1'b1, 5'd6, 32'd1100));
        check("fx_to poll", acc_at(base + 9), acc_word(1'b0, 5'd4, 32'd0));
        check("fx_to latency", 64'(stamp_at(base + 7) - stamp_at(base + 6)), 64'd19);
        check("fx_to err", 64'(timeout_err), 64'd1);
        check("fx_to count", 64'(sample_count), 64'(exp_count));
        check("fx_to sample", 64'(fx_sample), 64'(smp));
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_clr2", 64'(timeout_err), 64'd0);
        dp_respond = 1'b1;

        for (int k = 0; k < 6; k++)
            run_sample($urandom, $urandom, $urandom, $urandom, $urandom | 32'd1,
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                       $sformatf("rnd%0d", k));

        // Reset during the strobe phase of the input-sample read.
        load(32'd1, 32'd2, 32'd3, 32'd4, 32'd1);
        dp_ready_lat = 0; dp_res_lat = 0;
        @(negedge clk); enable = 1'b1;
        n = 0;
        while (!(loc_ramclk && loc_ramread && loc_ramaddress == 5'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rd_in reached", 64'(loc_ramclk && loc_ramread && loc_ramaddress == 5'd3), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst ramclk", 64'(loc_ramclk), 64'd0);
        check("mid_rst strobes", 64'({loc_ramread, loc_ramwrite}), 64'd0);
        check("mid_rst busy", 64'({busy, fx_valid}), 64'd0);
        enable = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        exp_count = '0;
        check("mid_rst count", 64'(sample_count), 64'd0);
        run_sample($urandom, $urandom, $urandom, $urandom, 32'd1, 1, 1, "restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
